// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and defaults for the data-memory arbiter.
//   owner_e            : tag recording which requester owns the read in flight
//   STARVE_LIMIT_DEF   : default number of consecutive conflicts the DMA may
//                        lose before it is given priority
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter for a single-port data memory. The core has
//   priority on conflicts; the DMA/loader wins after losing STARVE_LIMIT
//   conflicts in a row. Reads return one cycle later to the requester that
//   issued them.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      core request (held until cpu_gnt)
//   cpu_gnt, cpu_stall         core issued this cycle / core must freeze
//   cpu_rvalid, cpu_rdata      core read response (rdata 0 when not valid)
//   dma_*                      same set for the DMA/loader requester
//   mem_en/we/addr/wdata       memory strobe and muxed request (0 when idle)
//   mem_rdata                  memory read data, one cycle after a read strobe
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned   CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
   owner_e        owner_q;
   logic          conflict;
   logic          dma_wins;

   // Grant decision is purely combinational so the access issues in the
   // request cycle.
   always_comb begin
      conflict  = cpu_req & dma_req;
      dma_wins  = conflict & (starve_cnt == LIMIT);
      cpu_gnt   = cpu_req & ~dma_wins;
      dma_gnt   = dma_req & (~cpu_req | dma_wins);
      cpu_stall = cpu_req & ~cpu_gnt;
   end

   always_comb begin
      mem_en    = cpu_gnt | dma_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dma_gnt) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   // A conflict lost by the DMA only happens while starve_cnt < LIMIT, so the
   // increment can never pass the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (dma_gnt) begin
         starve_cnt <= '0;
      end else if (conflict && (starve_cnt < LIMIT)) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

   // Owner tag for the read in flight; cleared by reset so a pending response
   // is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= OWN_NONE;
      end else if (cpu_gnt && !cpu_we) begin
         owner_q <= OWN_CPU;
      end else if (dma_gnt && !dma_we) begin
         owner_q <= OWN_DMA;
      end else begin
         owner_q <= OWN_NONE;
      end
   end

   always_comb begin
      cpu_rvalid = (owner_q == OWN_CPU);
      dma_rvalid = (owner_q == OWN_DMA);
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      dma_rdata  = dma_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int unsigned LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_gnt, cpu_stall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   int total = 0;
   int bad   = 0;
   int m_starve = 0;

   typedef struct {
      logic        cg;
      logic        dg;
      logic        en;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gexp_t;

   typedef struct {
      logic        c;
      logic        d;
      logic [31:0] data;
   } rexp_t;

   rexp_t rsp_q[$];

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Read-only memory contents derived from the address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: data one cycle after a read strobe, junk otherwise so
   // that un-gated rdata shows up.
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
      else                   mem_rdata <= 32'hBAD0_0BAD;
   end

   // Response scoreboard: one entry per driven cycle, checked after the edge.
   always @(posedge clk) begin
      rexp_t e;
      #2;
      e = '{c: 1'b0, d: 1'b0, data: 32'h0};
      if (!rst_n) rsp_q.delete();
      else if (rsp_q.size() > 0) e = rsp_q.pop_front();
      total++;
      if (cpu_rvalid !== e.c || dma_rvalid !== e.d ||
          cpu_rdata !== (e.c ? e.data : 32'h0) || dma_rdata !== (e.d ? e.data : 32'h0)) begin
         bad++;
         $display("FAIL rsp t=%0t: got cv=%b dv=%b cd=%h dd=%h exp c=%b d=%b data=%h",
                  $time, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, e.c, e.d, e.data);
      end
   end

   // Drives one request cycle, predicts grants, advances the starvation model
   // and queues the expected response.
   task automatic drive_cycle(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                              input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              output gexp_t g);
      logic dwin;
      @(negedge clk);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      dwin    = cr && dr && (m_starve == LIMIT);
      g.cg    = cr && !dwin;
      g.dg    = dr && (!cr || dwin);
      g.en    = g.cg || g.dg;
      g.we    = g.cg ? cw : (g.dg ? dw : 1'b0);
      g.addr  = g.cg ? ca : (g.dg ? da : 32'h0);
      g.wdata = g.cg ? cd : (g.dg ? dd : 32'h0);
      if (g.dg)        m_starve = 0;
      else if (cr && dr) m_starve++;
      rsp_q.push_back('{c: g.cg && !cw, d: g.dg && !dw, data: mem_val(g.addr)});
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_rsp: cv=%b dv=%b cd=%h dd=%h required all 0", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
      end
      total++;
      if (dut.starve_cnt !== 3'd0) begin
         bad++;
         $display("FAIL reset_starve: got %0d required 0", dut.starve_cnt);
      end
      total++;
      if (mem_en !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: en=%b cg=%b dg=%b required 0", mem_en, cpu_gnt, dma_gnt);
      end
      rst_n = 1'b1;
      m_starve = 0;
   endtask

   task automatic test_cpu_read();
      gexp_t g;
      drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      total++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_en !== 1'b1 ||
          mem_we !== 1'b0 || mem_addr !== 32'h10) begin
         bad++;
         $display("FAIL cpu_read_issue: cg=%b dg=%b st=%b en=%b we=%b addr=%h required 1 0 0 1 0 00000010",
                  cpu_gnt, dma_gnt, cpu_stall, mem_en, mem_we, mem_addr);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL cpu_read_rsp: cv=%b cd=%h dv=%b required 1 deadbeef 0", cpu_rvalid, cpu_rdata, dma_rvalid);
      end
      total++;
      if (mem_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL idle_mux: en=%b we=%b addr=%h wd=%h required all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_dma_write();
      gexp_t g;
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, g);
      total++;
      if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
         bad++;
         $display("FAIL dma_write: dg=%b cg=%b en=%b we=%b addr=%h wd=%h required 1 0 1 1 00000040 12345678",
                  dma_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
   endtask

   task automatic test_conflict();
      gexp_t g;
      logic  dma_turn;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h0, g);
         dma_turn = ((i % 5) == 4);
         total++;
         if (cpu_gnt !== !dma_turn || dma_gnt !== dma_turn || cpu_stall !== dma_turn ||
             cpu_gnt !== g.cg || mem_addr !== g.addr) begin
            bad++;
            $display("FAIL conflict[%0d]: cg=%b dg=%b st=%b addr=%h required cg=%b dg=%b st=%b addr=%h",
                     i, cpu_gnt, dma_gnt, cpu_stall, mem_addr, !dma_turn, dma_turn, dma_turn, g.addr);
         end
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
   endtask

   task automatic test_back_to_back();
      gexp_t g;
      drive_cycle(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, g);
      total++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== mem_val(32'h100) || dma_rvalid !== 1'b0 || dma_gnt !== 1'b1) begin
         bad++;
         $display("FAIL b2b_cpu: cv=%b cd=%h dv=%b dg=%b required 1 %h 0 1",
                  cpu_rvalid, cpu_rdata, dma_rvalid, dma_gnt, mem_val(32'h100));
      end
      drive_cycle(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== mem_val(32'h200) || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
         bad++;
         $display("FAIL b2b_dma: dv=%b dd=%h cv=%b cd=%h required 1 %h 0 0",
                  dma_rvalid, dma_rdata, cpu_rvalid, cpu_rdata, mem_val(32'h200));
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
   endtask

   task automatic test_reset_inflight();
      gexp_t g;
      drive_cycle(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, g);
      drive_cycle(1'b1, 1'b0, 32'h504, 32'h0, 1'b1, 1'b0, 32'h604, 32'h0, g);
      drive_cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      total++;
      if (cpu_gnt !== 1'b1) begin
         bad++;
         $display("FAIL inflight_gnt: cg=%b required 1", cpu_gnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      cpu_req = 1'b0; dma_req = 1'b0;
      @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || dut.starve_cnt !== 3'd0) begin
         bad++;
         $display("FAIL inflight_drop: cv=%b dv=%b starve=%0d required 0 0 0", cpu_rvalid, dma_rvalid, dut.starve_cnt);
      end
      rst_n = 1'b1;
      m_starve = 0;
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
      drive_cycle(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0, g);
      total++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_conflict: cg=%b dg=%b required 1 0", cpu_gnt, dma_gnt);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
   endtask

   task automatic test_starve_clear();
      gexp_t g;
      // One conflict already lost above; two more reach a count of 3.
      for (int i = 0; i < 2; i++)
         drive_cycle(1'b1, 1'b1, 32'h700, 32'h1, 1'b1, 1'b0, 32'h800, 32'h0, g);
      @(negedge clk);
      total++;
      if (dut.starve_cnt !== 3'd3) begin
         bad++;
         $display("FAIL starve_three: got %0d required 3", dut.starve_cnt);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h900, 32'h0, g);
      total++;
      if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
         bad++;
         $display("FAIL dma_alone: dg=%b cg=%b required 1 0", dma_gnt, cpu_gnt);
      end
      drive_cycle(1'b1, 1'b0, 32'h904, 32'h0, 1'b1, 1'b0, 32'h908, 32'h0, g);
      total++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || dut.starve_cnt !== 3'd0) begin
         bad++;
         $display("FAIL starve_cleared: cg=%b dg=%b starve=%0d required 1 0 0", cpu_gnt, dma_gnt, dut.starve_cnt);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_conflict();
      test_back_to_back();
      test_reset_inflight();
      test_starve_clear();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost DMA conflicts before DMA wins priority.
REQ-002 The module SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port cpu_req  input  1  core requests a data-memory access this cycle.
REQ-005 The module SHALL have port cpu_we  input  1  core access is a write.
REQ-006 The module SHALL have port cpu_addr  input  32  core byte address.
REQ-007 The module SHALL have port cpu_wdata  input  32  core write data.
REQ-008 The module SHALL have port cpu_gnt  output  1  core access is issued to memory this cycle.
REQ-009 The module SHALL have port cpu_stall  output  1  cpu_req high and cpu_gnt low; freezes core PC and register writeback.
REQ-010 The module SHALL have port cpu_rvalid  output  1  cpu_rdata holds read data for the core.
REQ-011 The module SHALL have port cpu_rdata  output  32  read data returned to the core.
REQ-012 The module SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata with the same directions, widths and meanings as the cpu_ ports, for the DMA/loader requester.
REQ-013 The module SHALL have port mem_en  output  1  memory access strobe.
REQ-014 The module SHALL have port mem_we  output  1  memory write enable.
REQ-015 The module SHALL have port mem_addr  output  32  memory byte address.
REQ-016 The module SHALL have port mem_wdata  output  32  memory write data.
REQ-017 The module SHALL have port mem_rdata  input  32  memory read data, valid one cycle after a read strobe.

Function
REQ-018 Grant SHALL be combinational in the request cycle; at most one of cpu_gnt/dma_gnt high per cycle.
REQ-019 Single requester: that requester SHALL be granted.
REQ-020 Conflict (both req): CPU wins while starve_cnt < STARVE_LIMIT; DMA wins when starve_cnt == STARVE_LIMIT.
REQ-021 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each conflict lost by DMA, clear on any dma_gnt, hold otherwise; never exceed STARVE_LIMIT.
REQ-022 mem_en = cpu_gnt | dma_gnt; mem_we/mem_addr/mem_wdata SHALL mux from the granted requester; all zero when no grant.
REQ-023 Read response: granted read SHALL register owner tag (NONE/CPU/DMA); next cycle the owner's rvalid=1 and rdata=mem_rdata, the other requester's rvalid=0, rdata=0.
REQ-024 Writes SHALL produce no rvalid; read latency is exactly 1 cycle, throughput 1 access/cycle.
REQ-025 Back-to-back reads by alternating owners SHALL each return to the correct owner in order.
REQ-026 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
REQ-027 Requesters SHALL hold req/we/addr/wdata stable until granted; the arbiter does not buffer requests.

Reset
REQ-028 On rst_n low: starve_cnt=0, owner tag=NONE; cpu_rvalid=dma_rvalid=0, rdata=0; grants/mem_* follow REQ-018..022 combinationally.
REQ-029 Reset asserted while a read is in flight SHALL drop that response; no rvalid after release.
REQ-030 First conflict after reset SHALL go to the CPU.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold owner_e enum {OWN_NONE, OWN_CPU, OWN_DMA} and default STARVE_LIMIT constant.
REQ-032 No sub-module; counter, owner register and muxes live in dmem_arbiter.

Verification
REQ-033 CPU-only read addr 0x10, mem_rdata 0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid next cycle with cpu_rdata 0xDEADBEEF, dma_rvalid 0.
REQ-034 Both continuously request (STARVE_LIMIT=4) -> grant pattern CPU,CPU,CPU,CPU,DMA repeating; cpu_stall high only on DMA cycles.
REQ-035 DMA write addr 0x40 data 0x12345678 with no CPU req -> dma_gnt, mem_we=1, mem_addr 0x40, mem_wdata 0x12345678, no rvalid.
REQ-036 CPU read then DMA read in consecutive cycles -> cpu_rvalid cycle+1, dma_rvalid cycle+2, data matched to owner.
REQ-037 Assert rst_n low the cycle after a granted read -> no rvalid seen; starve_cnt 0; first post-reset conflict grants CPU.
REQ-038 starve_cnt=3, then DMA alone granted -> starve_cnt clears to 0; next conflict goes to CPU.
